// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller.
//   - opcode values of the 16-bit RISC ISA (Instruction[2:0])
//   - ALUControl and ALUSrcB codes as seen by the datapath
//   - controller state encoding (exported on the debug 'state' port)
//   - instruction-class helper used by the DECODE branch
package cpu_ctrl_pkg;

    localparam int CPU_OPCODE_W = 3;
    localparam int CPU_STATE_W  = 4;

    // Opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_BGT = 3'b111;

    // ALUControl codes
    localparam logic [1:0] ALUC_ADD = 2'b00;
    localparam logic [1:0] ALUC_SUB = 2'b01;
    localparam logic [1:0] ALUC_AND = 2'b10;
    localparam logic [1:0] ALUC_OR  = 2'b11;

    // ALUSrcB codes
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM_L = 2'b10; // imm7 = Instr[15:9]
    localparam logic [1:0] SRCB_IMM_S = 2'b11; // imm7 = {Instr[15:12], Instr[5:3]}

    // Controller states; codes 11..15 are unused and recover to IDLE.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LOADIR = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC_R = 4'd4,
        S_WB_R   = 4'd5,
        S_ADDR_L = 4'd6,
        S_WB_L   = 4'd7,
        S_ADDR_S = 4'd8,
        S_MEM_WR = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    // What the ALU is being asked to do in the current state.
    typedef enum logic [1:0] {
        ALU_CLS_ADD   = 2'd0, // address / PC arithmetic
        ALU_CLS_FUNCT = 2'd1, // R-type: operation comes from the opcode
        ALU_CLS_SUB   = 2'd2  // branch compare
    } alu_cls_t;

    typedef enum logic [1:0] {
        INSTR_R  = 2'd0,
        INSTR_LW = 2'd1,
        INSTR_SW = 2'd2,
        INSTR_BR = 2'd3
    } instr_cls_t;

    function automatic instr_cls_t op_class(input logic [2:0] op);
        instr_cls_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = INSTR_R;
            OP_LW:                         cls = INSTR_LW;
            OP_SW:                         cls = INSTR_SW;
            OP_BEQ, OP_BGT:                cls = INSTR_BR;
            default:                       cls = INSTR_R;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// ALU operation decoder.
//   funct       in  2  opcode[1:0] of the current instruction
//   cls         in     ALU usage class of the current controller state
//   alu_control out 2  ALUControl to the datapath
// R-type execution passes the opcode's low bits straight through, so a change
// of opcode while in EXEC_R is reflected in the same cycle.
module alu_op_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [1:0] funct,
    input  alu_cls_t   cls,
    output logic [1:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        case (cls)
            ALU_CLS_SUB: alu_control = ALUC_SUB;
            ALU_CLS_FUNCT: begin
                case (funct)
                    2'b00:   alu_control = ALUC_ADD;
                    2'b01:   alu_control = ALUC_SUB;
                    2'b10:   alu_control = ALUC_AND;
                    default: alu_control = ALUC_OR;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle main controller for the 16-bit RISC datapath.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath control strobe each cycle. Outputs are a function of the state
// only, except ALUControl in EXEC_R and z/g in BRANCH, which follow the opcode.
//   clk, rst      clock, synchronous active-high reset
//   start         leave IDLE and begin fetching (ignored elsewhere)
//   opcode        Instruction[2:0] from IR
//   PCSrc..MemWrite  datapath control strobes
//   busy          high in every state except IDLE
//   instr_done    one-cycle pulse in the last state of each instruction
//   state         current state code (debug)
// Valid/ready: there is no handshake; start is a level sampled only in IDLE.
module multicycle_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = CPU_OPCODE_W,
    parameter int STATE_W  = CPU_STATE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                PCSrc,
    output logic                PC_write,
    output logic                IPR_enable,
    output logic                IR_enable,
    output logic                IM_sel,
    output logic                RegWrite,
    output logic                z,
    output logic                g,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUControl,
    output logic                MemtoReg,
    output logic                MemWrite,
    output logic                busy,
    output logic                instr_done,
    output logic [STATE_W-1:0]  state
);

    state_t   state_q, state_d;
    alu_cls_t alu_cls;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCSrc      = 1'b0;
        PC_write   = 1'b0;
        IPR_enable = 1'b0;
        IR_enable  = 1'b0;
        RegWrite   = 1'b0;
        z          = 1'b0;
        g          = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        alu_cls    = ALU_CLS_ADD;
        MemtoReg   = 1'b0;
        MemWrite   = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC <= PC + 1 while the prefetch register captures IMEM[PC]
                IPR_enable = 1'b1;
                ALUSrcB    = SRCB_ONE;
                PC_write   = 1'b1;
                state_d    = S_LOADIR;
            end
            S_LOADIR: begin
                IR_enable = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                case (op_class(opcode[2:0]))
                    INSTR_LW: state_d = S_ADDR_L;
                    INSTR_SW: state_d = S_ADDR_S;
                    INSTR_BR: state_d = S_BRANCH;
                    default:  state_d = S_EXEC_R;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REGB;
                alu_cls = ALU_CLS_FUNCT;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDR_L: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM_L;
                state_d = S_WB_L;
            end
            S_WB_L: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDR_S: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM_S;
                state_d = S_MEM_WR;
            end
            S_MEM_WR: begin
                MemWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                // Compare regA - regB; the datapath loads the target into PC
                // only when the enabled flag is set, so PC_write stays low.
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_REGB;
                alu_cls    = ALU_CLS_SUB;
                PCSrc      = 1'b1;
                z          = ~opcode[0];
                g          = opcode[0];
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    alu_op_decoder u_alu_op_decoder (
        .funct       (opcode[1:0]),
        .cls         (alu_cls),
        .alu_control (ALUControl)
    );

    assign IM_sel = 1'b0;
    assign busy   = (state_q != S_IDLE);
    assign state  = state_q;

endmodule
